// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: memory-mapped 8N1 UART transmitter.
// Byte FIFO, programmable baud divisor, status/divisor readback.
module uart_tx_ctrl #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_sel,
  input  logic        uart_wr,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [15:0]   r_div;

  state_t        r_state;
  logic [15:0]   r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [15:0]   r_fdiv;
  logic          r_tx;

  logic          w_wr;
  logic          w_push;
  logic          w_clr;
  logic          w_ldiv;
  logic          w_full;
  logic          w_empty;
  logic          w_acc;
  logic          w_pop;
  logic [7:0]    w_head;
  logic [15:0]   w_lim;
  logic          w_tick;

  state_t        w_nxt;
  logic [15:0]   w_cnt_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_shift_nxt;
  logic [15:0]   w_fdiv_nxt;
  logic          w_tx_nxt;

  assign w_wr    = uart_sel & uart_wr;
  assign w_push  = w_wr & (addr == 4'h0);
  assign w_clr   = w_wr & (addr == 4'h4) & wdata[3];
  assign w_ldiv  = w_wr & (addr == 4'h8);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // a push into a full FIFO still lands if the same cycle frees a slot
  assign w_acc   = w_push & (~w_full | w_pop);
  assign w_head  = r_mem[r_rptr];
  assign w_lim   = (r_fdiv == 16'd0) ? 16'd1 : r_fdiv;
  assign w_tick  = (r_cnt == w_lim - 16'd1);

  assign uart_tx = r_tx;
  assign tx_busy = (r_state != S_IDLE) | ~w_empty;

  // FIFO storage, pointers, count and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_mem[r_wptr] <= wdata[7:0];
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push & ~w_acc) r_ovf <= 1'b1;
      else if (w_clr)      r_ovf <= 1'b0;
    end
  end

  // programmable divisor; frames use their own latched copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_div <= DEFAULT_DIV;
    else if (w_ldiv) r_div <= wdata[15:0];
  end

  // TX state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_fdiv  <= DEFAULT_DIV;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_fdiv  <= w_fdiv_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // next state, FIFO pop and next line level
  always_comb begin
    w_nxt       = r_state;
    w_pop       = 1'b0;
    w_cnt_nxt   = r_cnt + 16'd1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_fdiv_nxt  = r_fdiv;
    w_tx_nxt    = r_tx;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 16'd0;
        w_tx_nxt  = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nxt       = S_START;
          w_shift_nxt = w_head;
          w_fdiv_nxt  = r_div;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_nxt     = S_DATA;
          w_cnt_nxt = 16'd0;
          w_bit_nxt = 3'd0;
          w_tx_nxt  = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_nxt = 16'd0;
          if (r_bit == 3'd7) begin
            w_nxt    = S_STOP;
            w_tx_nxt = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_cnt_nxt = 16'd0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_nxt       = S_START;
            w_shift_nxt = w_head;
            w_fdiv_nxt  = r_div;
            w_tx_nxt    = 1'b0;
          end else begin
            w_nxt    = S_IDLE;
            w_tx_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_nxt    = S_IDLE;
        w_tx_nxt = 1'b1;
      end
    endcase
  end

  // register readback, no latency
  always_comb begin
    rdata = 32'h0;
    case (addr)
      4'h4:    rdata = {28'h0, r_ovf, w_empty, w_full, tx_busy};
      4'h8:    rdata = {16'h0, r_div};
      default: rdata = 32'h0;
    endcase
  end

endmodule
